// File: rtl/nes_joypad_port_if.sv
// CPU-side bus of the NES joypad port: strobe register write, read pulse
// and the serial data bit returned to the CPU.
interface nes_joypad_port_if;
   logic strobe_we;
   logic strobe_d;
   logic rd_pulse;
   logic dout;

   // CPU / bus side
   modport master (
      output strobe_we,
      output strobe_d,
      output rd_pulse,
      input  dout
   );

   // Joypad port side
   modport slave (
      input  strobe_we,
      input  strobe_d,
      input  rd_pulse,
      output dout
   );
endinterface

// File: rtl/nes_joypad_port.sv
// NES joypad port: synchronizes and debounces the raw button vector,
// suppresses impossible d-pad combinations, applies turbo to A/B and
// serializes the result through the classic strobe/read shift register.
module nes_joypad_port #(
   parameter int unsigned STABLE_CYC = 4,
   parameter int unsigned TURBO_W    = 20
) (
   input  logic               nesclk,
   input  logic               nesrst_n,
   input  logic [7:0]         btn_nes,
   input  logic               conerr,
   input  logic [1:0]         turbo_en,
   nes_joypad_port_if.slave   cpu,
   output logic [7:0]         btn_cur
);

   logic [7:0]         btn_s1;
   logic [7:0]         btn_s2;
   logic               err_s1;
   logic               err_s2;
   logic [7:0]         btn_last;
   logic [7:0]         stab_cnt;
   logic [7:0]         btn_stable;
   logic [TURBO_W-1:0] div;
   logic               phase;
   logic               strobe_q;
   logic [7:0]         shreg;
   logic [7:0]         btn_nxt;

   // Two-flop synchronizers for the asynchronous button vector and link error
   always_ff @(posedge nesclk or negedge nesrst_n) begin
      if (!nesrst_n) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
         err_s1 <= 1'b0;
         err_s2 <= 1'b0;
      end else begin
         btn_s1 <= btn_nes;
         btn_s2 <= btn_s1;
         err_s1 <= conerr;
         err_s2 <= err_s1;
      end
   end

   // Debounce: commit the vector once it has matched for STABLE_CYC cycles;
   // a link error overrides and holds the committed vector at zero
   always_ff @(posedge nesclk or negedge nesrst_n) begin
      if (!nesrst_n) begin
         btn_last   <= '0;
         stab_cnt   <= '0;
         btn_stable <= '0;
      end else begin
         btn_last <= btn_s2;
         if (btn_s2 != btn_last) begin
            stab_cnt <= '0;
         end else if (stab_cnt != 8'(STABLE_CYC)) begin
            stab_cnt <= stab_cnt + 8'd1;
         end
         if (err_s2) begin
            btn_stable <= '0;
         end else if (stab_cnt == 8'(STABLE_CYC)) begin
            btn_stable <= btn_last;
         end
      end
   end

   // Free-running turbo divider; phase flips each time the divider wraps
   always_ff @(posedge nesclk or negedge nesrst_n) begin
      if (!nesrst_n) begin
         div   <= '0;
         phase <= 1'b0;
      end else begin
         div <= div + TURBO_W'(1);
         if (div == '1) begin
            phase <= ~phase;
         end
      end
   end

   // D-pad conflict removal, turbo gating and reorder into NES shift order;
   // the error mask is applied here too so the output clears without
   // waiting an extra cycle for btn_stable
   always_comb begin
      logic [7:0] v;
      logic       a_g;
      logic       b_g;
      v = err_s2 ? 8'h00 : btn_stable;
      if (v[7] && v[6]) begin
         v[7] = 1'b0;
         v[6] = 1'b0;
      end
      if (v[5] && v[4]) begin
         v[5] = 1'b0;
         v[4] = 1'b0;
      end
      a_g     = v[0] & (~turbo_en[0] | phase);
      b_g     = v[1] & (~turbo_en[1] | phase);
      btn_nxt = {v[5], v[4], v[6], v[7], v[3], v[2], b_g, a_g};
   end

   // Registered processed button vector
   always_ff @(posedge nesclk or negedge nesrst_n) begin
      if (!nesrst_n) begin
         btn_cur <= '0;
      end else begin
         btn_cur <= btn_nxt;
      end
   end

   // Strobe register and shift register; the pre-edge strobe value decides
   // between load and shift, so a coincident strobe write takes effect next cycle
   always_ff @(posedge nesclk or negedge nesrst_n) begin
      if (!nesrst_n) begin
         strobe_q <= 1'b0;
         shreg    <= '0;
      end else begin
         if (cpu.strobe_we) begin
            strobe_q <= cpu.strobe_d;
         end
         if (strobe_q) begin
            shreg <= btn_cur;
         end else if (cpu.rd_pulse) begin
            shreg <= {1'b1, shreg[7:1]};
         end
      end
   end

   assign cpu.dout = shreg[0];

endmodule
